// File: rtl/enc_8x3_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enc_8x3_scan: captures an active-low 8-line request vector, then emits   |
// | the index of each requested line, lowest first, over a valid/ready link. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module enc_8x3_scan (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] in_n,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [2:0] y,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       last,
   output logic       none,
   output logic [3:0] cnt
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pending_q, pending_d;
   logic [3:0] cnt_q, cnt_d;
   logic       zero_q, zero_d;

   logic       w_scan;
   logic [2:0] w_low_idx;
   logic       w_onehot;
   logic       w_last;
   logic [3:0] w_pop;

   always_comb begin
      w_low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pending_q[i]) w_low_idx = 3'(i);
      end
      w_pop = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_pop = w_pop + {3'b000, ~in_n[i]};
      end
   end

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   assign w_onehot  = (pending_q != 8'h00) && ((pending_q & (pending_q - 8'd1)) == 8'h00);
   assign w_scan    = (state_q == S_SCAN);
   assign w_last    = zero_q | w_onehot;

   assign out_valid = w_scan;
   assign y         = w_scan ? w_low_idx : 3'd0;
   assign last      = w_scan & w_last;
   assign none      = w_scan & zero_q;
   assign cnt       = cnt_q;
   assign in_ready  = rst_n & ~en & (state_q == S_IDLE);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      zero_d    = zero_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               pending_d = ~in_n;
               cnt_d     = w_pop;
               zero_d    = (in_n == 8'hFF);
               state_d   = S_SCAN;
            end
         end
         S_SCAN: begin
            if (out_ready) begin
               pending_d[w_low_idx] = 1'b0;
               if (w_last) begin
                  state_d   = S_IDLE;
                  pending_d = 8'h00;
               end
            end
            // A transfer at the abort edge still counts; the rest are dropped.
            if (en) begin
               state_d   = S_IDLE;
               pending_d = 8'h00;
            end
         end
         default: begin
            state_d   = S_IDLE;
            pending_d = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pending_q <= 8'h00;
         cnt_q     <= 4'd0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         zero_q    <= zero_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_enc_8x3_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_enc_8x3_scan: self-checking bench for enc_8x3_scan.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_enc_8x3_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [7:0] in_n = 8'hFF;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, last, none;
   logic [2:0] y;
   logic [3:0] cnt;

   enc_8x3_scan dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_n      (in_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .last      (last),
      .none      (none),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference: the captured vector as a queue of line indices still owed.
   bit m_busy = 1'b0;
   bit m_zero = 1'b0;
   int m_cnt  = 0;
   int m_q[$];
   int got[$];

   typedef struct {
      logic [7:0] in_n;
      int         first_y;
      int         exp_cnt;
      int         exp_none;
      int         n_codes;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Called at a falling edge with inputs already set; checks then crosses one rising edge.
   task automatic step();
      int ey;
      #1;
      if (!rst_n) begin
         m_busy = 0; m_zero = 0; m_cnt = 0; m_q.delete();
      end
      ey = (m_busy && !m_zero) ? m_q[0] : 0;
      chk("in_ready",  in_ready,  (!m_busy && !en && rst_n) ? 1 : 0);
      chk("out_valid", out_valid, m_busy ? 1 : 0);
      chk("y",         y,         ey);
      chk("last",      last,      (m_busy && (m_zero || m_q.size() == 1)) ? 1 : 0);
      chk("none",      none,      (m_busy && m_zero) ? 1 : 0);
      chk("cnt",       cnt,       m_cnt);
      if (out_valid && out_ready && rst_n) got.push_back(int'(y));
      @(posedge clk);
      if (rst_n) begin
         if (!m_busy) begin
            if (in_valid && !en) begin
               m_q.delete();
               for (int i = 0; i < 8; i++) if (!in_n[i]) m_q.push_back(i);
               m_cnt  = m_q.size();
               m_zero = (m_q.size() == 0);
               m_busy = 1;
            end
         end else begin
            if (out_ready) begin
               if (m_zero || m_q.size() == 1) begin
                  m_busy = 0; m_q.delete();
               end else begin
                  void'(m_q.pop_front());
               end
            end
            if (en) begin
               m_busy = 0; m_q.delete();
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic capture(input logic [7:0] v, input logic rdy);
      in_n = v; in_valid = 1'b1; out_ready = rdy; en = 1'b0;
      step();
      in_valid = 1'b0; in_n = 8'hFF;
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      out_ready = 1'b1;
      while (m_busy && n < max_cycles) begin
         step();
         n++;
      end
      chk("drain_timeout", m_busy ? 1 : 0, 0);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{8'b11111011, 2, 1, 0, 1};
      vecs[1] = '{8'b01011010, 0, 4, 0, 4};
      vecs[2] = '{8'hFF,       0, 0, 1, 1};
      vecs[3] = '{8'h00,       0, 8, 0, 8};
      vecs[4] = '{8'h7F,       7, 1, 0, 1};

      // Reset held with a pending request offered
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; in_valid = 1'b1; in_n = 8'h00;
      step();
      step();
      rst_n = 1'b1; in_valid = 1'b0; in_n = 8'hFF;
      step();

      // Table of vectors, each drained with out_ready held high
      for (int v = 0; v < 5; v++) begin
         got.delete();
         capture(vecs[v].in_n, 1'b1);
         #1;
         chk("tbl_first_y", y,    vecs[v].first_y);
         chk("tbl_cnt",     cnt,  vecs[v].exp_cnt);
         chk("tbl_none",    none, vecs[v].exp_none);
         drain(12);
         chk("tbl_ncodes", got.size(), vecs[v].n_codes);
         if (v == 1 && got.size() == 4) begin
            chk("seq0", got[0], 0);
            chk("seq1", got[1], 2);
            chk("seq2", got[2], 5);
            chk("seq3", got[3], 7);
         end
         step();
      end

      // Backpressure: first code must hold for three stalled cycles
      got.delete();
      capture(8'b01011010, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_hold_y", y, 0);
         chk("bp_hold_valid", out_valid, 1);
         @(negedge clk);
         step();
      end
      drain(8);
      chk("bp_ncodes", got.size(), 4);
      step();

      // Abort through en after two transfers
      got.delete();
      capture(8'h00, 1'b1);
      step();
      step();
      out_ready = 1'b0; en = 1'b1;
      step();
      step();
      chk("abort_ncodes", got.size(), 2);
      chk("abort_valid", out_valid, 0);
      chk("abort_ready", in_ready, 0);
      en = 1'b0;
      step();

      // Reset pulsed mid-scan
      got.delete();
      capture(8'h00, 1'b1);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_y", y, 0);
      chk("rst_mid_cnt", cnt, 0);
      @(negedge clk);
      step();
      rst_n = 1'b1; out_ready = 1'b0;
      step();

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 15) == 0);
         in_valid  = $urandom_range(0, 1);
         in_n      = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 99) != 0);
         step();
      end
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
